// File: rtl/blink_pkg.sv
// Shared types and constants for the score blinker.
// State encoding, score width and default blink timing.
package blink_pkg;

  localparam int SCORE_W        = 4;
  localparam int DEF_ON_CYCLES  = 25_000_000;
  localparam int DEF_OFF_CYCLES = 25_000_000;

  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF,
    FINISH
  } state_t;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter timing one ON or OFF phase.
// Loading value L keeps the phase alive for L+1 cycles.
module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;

  // Load takes priority; otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/score_blinker.sv
// Blinks an LED SCORE times per START request, then pulses DONE.
// SCORE_BLINKER_ZERO_BLINK_EN: a zero score gives one long blink.
module score_blinker
  import blink_pkg::*;
#(
  parameter int ON_CYCLES  = DEF_ON_CYCLES,
  parameter int OFF_CYCLES = DEF_OFF_CYCLES
) (
  input  logic               clk,
  input  logic               RST_N,
  input  logic               START,
  input  logic [SCORE_W-1:0] SCORE,
  output logic               LED,
  output logic               BUSY,
  output logic               DONE
);

  localparam int TW =
    $clog2(4 * ON_CYCLES + OFF_CYCLES + 1);

  localparam logic [TW-1:0] ON_LD  =
    TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LD =
    TW'(OFF_CYCLES - 1);
`ifdef SCORE_BLINKER_ZERO_BLINK_EN
  localparam logic [TW-1:0] LONG_LD =
    TW'(4 * ON_CYCLES - 1);
`endif

  state_t               r_state;
  state_t               w_next;
  logic [SCORE_W-1:0]   r_count;
  logic                 w_load;
  logic [TW-1:0]        w_load_val;
  logic                 w_latch;
  logic                 w_dec;
  logic                 w_expired;

  phase_timer #(
    .W(TW)
  ) u_timer (
    .clk       (clk),
    .rst_n     (RST_N),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .o_expired (w_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Blink counter: latched at start, stepped down after each OFF.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_count <= '0;
    end else if (w_latch) begin
      r_count <= SCORE;
    end else if (w_dec && r_count != '0) begin
      r_count <= r_count - SCORE_W'(1);
    end
  end

  // Next state plus timer load on every entry to ON/OFF.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = ON_LD;
    w_latch    = 1'b0;
    w_dec      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (START) begin
          w_latch = 1'b1;
          if (SCORE != '0) begin
            w_next = ON;
            w_load = 1'b1;
          end else begin
`ifdef SCORE_BLINKER_ZERO_BLINK_EN
            w_next     = ON;
            w_load     = 1'b1;
            w_load_val = LONG_LD;
`else
            w_next = FINISH;
`endif
          end
        end
      end
      ON: begin
        if (w_expired) begin
          w_next     = OFF;
          w_load     = 1'b1;
          w_load_val = OFF_LD;
        end
      end
      OFF: begin
        if (w_expired) begin
          w_dec = 1'b1;
          if (r_count <= SCORE_W'(1)) begin
            w_next = FINISH;
          end else begin
            w_next = ON;
            w_load = 1'b1;
          end
        end
      end
      FINISH: begin
        w_next = IDLE;
      end
    endcase
  end

  assign LED  = (r_state == ON);
  assign BUSY = (r_state == ON) || (r_state == OFF);
  assign DONE = (r_state == FINISH);

endmodule

// File: doc/score_blinker.md
SCORE_BLINKER -- requirements
Module: score_blinker

Interface
REQ-001 Parameter ON_CYCLES, default 25_000_000, sets the clock cycles the LED is lit per blink; legal minimum is 1.
REQ-002 Parameter OFF_CYCLES, default 25_000_000, sets the clock cycles the LED is dark after each blink; legal minimum is 1.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port RST_N  input  1  is the reset: asynchronous assertion, active-low.
REQ-005 Port START  input  1  is a request to display SCORE; it is sampled only in IDLE.
REQ-006 Port SCORE  input  4  is the unsigned score value produced by the score accumulator.
REQ-007 Port LED  output  1  is the blink output; 1 means lit.
REQ-008 Port BUSY  output  1  is high while a display sequence is in progress.
REQ-009 Port DONE  output  1  is a one-cycle pulse when a sequence completes.

Function
REQ-010 The FSM SHALL have exactly four states: IDLE, ON, OFF and FINISH.
REQ-011 In IDLE with START=1, the block SHALL latch SCORE into a 4-bit count register at that edge.
  - Latched score nonzero: next state is ON.
  - Latched score zero: next state is FINISH (macro-off behaviour, see REQ-021).
REQ-012 The block SHALL stay in ON for exactly ON_CYCLES cycles with LED=1, then go to OFF.
REQ-013 The block SHALL stay in OFF for exactly OFF_CYCLES cycles with LED=0.
  - On leaving OFF, the count register decrements.
  - Count was 1: next state is FINISH; otherwise next state is ON.
REQ-014 FINISH SHALL last one cycle with DONE=1 and return to IDLE.
REQ-015 The outputs SHALL be decoded from state only (Moore): LED=1 only in ON; BUSY=1 in ON and OFF only; DONE=1 in FINISH only.
REQ-016 For score N>0, the first LED-high cycle SHALL be the cycle after the START edge, and DONE SHALL assert exactly N*(ON_CYCLES+OFF_CYCLES)+1 cycles after the START edge.
REQ-017 START SHALL be ignored in ON, OFF and FINISH, and changes to SCORE after latching SHALL have no effect.
REQ-018 START held high continuously SHALL restart a new sequence on the first IDLE cycle after FINISH, with a freshly latched SCORE.
REQ-019 SCORE=15 SHALL produce exactly 15 blinks; the count register SHALL never wrap.

Reset
REQ-020 While RST_N=0, the block SHALL be in IDLE with LED=0, BUSY=0, DONE=0, the count register at 0 and the phase timer at 0; this holds even mid-sequence, with no DONE pulse, and the block resumes in IDLE after release.

Configuration
REQ-021 Macro SCORE_BLINKER_ZERO_BLINK_EN SHALL select the zero-score behaviour.
  - Defined: a latched zero SHALL produce one long blink, ON held for 4*ON_CYCLES cycles, then OFF_CYCLES cycles, then FINISH.
  - Undefined: a latched zero SHALL go directly to FINISH; DONE appears 1 cycle after the START edge and the LED is never lit.

Structure
REQ-022 Shared package blink_pkg SHALL hold:
  - the state enum typedef (IDLE, ON, OFF, FINISH);
  - the score width constant SCORE_W=4;
  - the default ON/OFF cycle constants.
REQ-023 Sub-module phase_timer SHALL implement the phase counter.
  - It is a loadable down-counter with inputs load and load value, and output expired.
  - The top FSM SHALL load it on every state entry into ON and OFF.

Verification (ON_CYCLES=3, OFF_CYCLES=2)
REQ-024 SCORE=3, START pulse at cycle 0 -> LED high in cycles 1-3, 6-8 and 11-13; BUSY high in cycles 1-15; DONE high in cycle 16 only.
REQ-025 SCORE=0, macro off -> DONE in cycle 1, LED never high. Macro on -> LED high in cycles 1-12, DONE in cycle 15.
REQ-026 SCORE=2 with START, then SCORE changed to 9 and START pulsed at cycle 4 -> exactly 2 blinks, DONE in cycle 11.
REQ-027 SCORE=15, START held high throughout -> 15 blinks, DONE in cycle 76, then a second sequence with LED high starting in cycle 78.
REQ-028 SCORE=5, RST_N low at cycle 7 for 2 cycles -> LED, BUSY and DONE are 0 immediately (asynchronous); no DONE pulse follows; a new START then yields a full 5-blink sequence.
